alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (>=2).
REQ-002 Parameter DEPTH, default 16, program memory entries (power of two, >=2); ADDR_W = $clog2(DEPTH).
REQ-003 clock  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  begin program run from address 0; sampled only in IDLE.
REQ-006 prog_we  input  1  program memory write enable; honoured only in IDLE.
REQ-007 prog_addr  input  ADDR_W  program write address.
REQ-008 prog_data  input  4+2*WIDTH  instruction {halt[1], op[3], a[WIDTH], b[WIDTH]}, MSB first.
REQ-009 result  output  WIDTH  registered ALU result.
REQ-010 result_valid  output  1  result holds an unaccepted value.
REQ-011 result_ready  input  1  consumer accepts result when result_valid & result_ready.
REQ-012 flag_zero, flag_carry, flag_neg  output  1 each  registered status flags for result.
REQ-013 busy  output  1  high whenever state != IDLE.
REQ-014 done  output  1  single-cycle pulse at end of run.
REQ-015 pc  output  ADDR_W  address of next instruction to execute.

Function
REQ-016 Ops: 000 ADD a+b; 001 SUB a+~b+1; 010 SHL a<<b; 011 SHR a>>b (logical); 100 AND; 101 OR; 110 XOR; 111 NOT a (b ignored); all results truncated to WIDTH.
REQ-017 Shifts with b >= WIDTH SHALL yield 0.
REQ-018 Program memory: synchronous write, combinational read; write in same cycle as start SHALL be visible to the run.
REQ-019 States: IDLE, RUN, DONE.
REQ-020 IDLE -> RUN on start; pc = 0.
REQ-021 In RUN, when result_valid=0 or the current result is accepted, instruction at pc SHALL be executed, result/flags registered, result_valid set, pc incremented (one instruction per cycle at full throughput).
REQ-022 In RUN with result_valid=1 and result_ready=0, result, flags and pc SHALL hold stable.
REQ-023 After executing an instruction with halt=1 or at address DEPTH-1, no further instruction issues; RUN -> DONE on acceptance of that final result; pc wraps to 0.
REQ-024 DONE: done=1, result_valid=0 for exactly one cycle, then IDLE.
REQ-025 start, prog_we while busy SHALL be ignored.

Reset
REQ-026 reset SHALL force IDLE, pc=0, result=0, result_valid=0, flags=0, done=0, busy=0 immediately, including mid-run.
REQ-027 Program memory contents SHALL NOT be affected by reset.

Configuration
REQ-028 Macro ALU_SEQ_FLAGS_EN defined: flag_zero = (result==0), flag_carry = carry-out of ADD / no-borrow of SUB / last bit shifted out of SHL/SHR / 0 otherwise, flag_neg = result[WIDTH-1], registered with result.
REQ-029 Macro ALU_SEQ_FLAGS_EN undefined: flag ports present, tied to 0, no flag logic.

Structure
REQ-030 Package alu_seq_pkg: op enum (ADD..NOT), state enum, instruction field offsets/width functions of WIDTH.
REQ-031 Sub-module alu_core: combinational, parametrised by WIDTH, op/a/b in, result and carry out.

Verification (WIDTH=8, DEPTH=16)
REQ-032 Load 0:{0,ADD,0x17,0x13}, 1:{0,SUB,0x0C,0x0D}, 2:{1,SHL,0x05,0x02}; start, ready=1 -> results 0x2A, 0xFF, 0x14 on consecutive cycles, then done one cycle, busy low after.
REQ-033 Same program, result_ready low 3 cycles on second result -> result 0xFF and pc held stable 3 cycles, then run resumes, no result lost or duplicated.
REQ-034 {1,SHR,0x80,0x09} -> 0x00; {1,NOT,0x5A,0x00} -> 0xA5.
REQ-035 16 entries with halt=0 -> exactly 16 results, done pulse, pc=0.
REQ-036 reset asserted after second result -> all outputs 0, IDLE; restart yields identical result sequence (memory retained).
REQ-037 {1,ADD,0xFF,0x01} -> result 0x00; with ALU_SEQ_FLAGS_EN zero=1, carry=1, neg=0; without, all flags 0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and instruction layout for the ALU sequencer.
// The instruction word is {halt, op[2:0], a[WIDTH-1:0], b[WIDTH-1:0]}, MSB first.
package alu_seq_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_SHL = 3'b010,
        OP_SHR = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_NOT = 3'b111
    } aluOp_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seqState_e;

    function automatic int instrWidth(input int width);
        return 4 + 2 * width;
    endfunction

    function automatic int bLsb(input int width);
        return 0 * width;
    endfunction

    function automatic int aLsb(input int width);
        return width;
    endfunction

    function automatic int opLsb(input int width);
        return 2 * width;
    endfunction

    function automatic int haltBit(input int width);
        return 2 * width + OP_W;
    endfunction

endpackage

// File: rtl/alu_seq_alu_core.sv
// Combinational ALU used by the sequencer; carry_o is the ADD carry-out,
// the SUB no-borrow, or the last bit shifted out of SHL/SHR.
module alu_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  aluOp_e           op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o
);

    logic [WIDTH:0] ext;

    // Shifts work on a one-bit-extended operand so the bit falling off the end
    // lands in the extension; any shift of WIDTH or more leaves a zero result.
    always_comb begin
        ext      = '0;
        result_o = '0;
        carry_o  = 1'b0;
        case (op_i)
            OP_ADD: begin
                ext      = {1'b0, a_i} + {1'b0, b_i};
                result_o = ext[WIDTH-1:0];
                carry_o  = ext[WIDTH];
            end
            OP_SUB: begin
                ext      = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
                result_o = ext[WIDTH-1:0];
                carry_o  = ext[WIDTH];
            end
            OP_SHL: begin
                ext      = {1'b0, a_i} << b_i;
                result_o = ext[WIDTH-1:0];
                carry_o  = ext[WIDTH];
            end
            OP_SHR: begin
                ext      = {a_i, 1'b0} >> b_i;
                result_o = ext[WIDTH:1];
                carry_o  = ext[0];
            end
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_NOT:  result_o = ~a_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Program-memory driven ALU sequencer with a valid/ready result port.
// Define ALU_SEQ_FLAGS_EN to register zero/carry/negative flags; otherwise they read 0.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          prog_we,
    input  logic [$clog2(DEPTH)-1:0]      prog_addr,
    input  logic [instrWidth(WIDTH)-1:0]  prog_data,
    output logic [WIDTH-1:0]              result,
    output logic                          result_valid,
    input  logic                          result_ready,
    output logic                          flag_zero,
    output logic                          flag_carry,
    output logic                          flag_neg,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(DEPTH)-1:0]      pc
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int IW     = instrWidth(WIDTH);
    localparam int A_LSB  = aLsb(WIDTH);
    localparam int B_LSB  = bLsb(WIDTH);
    localparam int OP_LSB = opLsb(WIDTH);
    localparam int HALT_B = haltBit(WIDTH);

    logic [IW-1:0] progMem [DEPTH];

    seqState_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              resultValid_q, resultValid_d;
    logic              lastIssued_q, lastIssued_d;
    logic              issue;

    logic [IW-1:0]     curInstr;
    logic              curHalt;
    aluOp_e            curOp;
    logic [WIDTH-1:0]  curA;
    logic [WIDTH-1:0]  curB;
    logic [WIDTH-1:0]  aluResult;
    logic              aluCarry;

    // Program memory is deliberately outside the reset domain so a reset keeps the loaded program.
    always_ff @(posedge clock) begin
        if (prog_we && (state_q == ST_IDLE)) begin
            progMem[prog_addr] <= prog_data;
        end
    end

    assign curInstr = progMem[pc_q];
    assign curHalt  = curInstr[HALT_B];
    assign curOp    = aluOp_e'(curInstr[OP_LSB +: OP_W]);
    assign curA     = curInstr[A_LSB +: WIDTH];
    assign curB     = curInstr[B_LSB +: WIDTH];

    alu_core #(
        .WIDTH(WIDTH)
    ) u_alu_core (
        .op_i    (curOp),
        .a_i     (curA),
        .b_i     (curB),
        .result_o(aluResult),
        .carry_o (aluCarry)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= '0;
            result_q      <= '0;
            resultValid_q <= 1'b0;
            lastIssued_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            result_q      <= result_d;
            resultValid_q <= resultValid_d;
            lastIssued_q  <= lastIssued_d;
        end
    end

    // lastIssued_q marks that the final instruction is out, so RUN only waits for its acceptance.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        result_d      = result_q;
        resultValid_d = resultValid_q;
        lastIssued_d  = lastIssued_q;
        issue         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_RUN;
                    pc_d          = '0;
                    resultValid_d = 1'b0;
                    lastIssued_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (resultValid_q && result_ready && lastIssued_q) begin
                    state_d       = ST_DONE;
                    resultValid_d = 1'b0;
                    pc_d          = '0;
                end else if ((!resultValid_q || result_ready) && !lastIssued_q) begin
                    issue         = 1'b1;
                    result_d      = aluResult;
                    resultValid_d = 1'b1;
                    pc_d          = pc_q + 1'b1;
                    lastIssued_d  = curHalt || (pc_q == ADDR_W'(DEPTH - 1));
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic flagZero_q, flagCarry_q, flagNeg_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flagZero_q  <= 1'b0;
            flagCarry_q <= 1'b0;
            flagNeg_q   <= 1'b0;
        end else if (issue) begin
            flagZero_q  <= (aluResult == '0);
            flagCarry_q <= aluCarry;
            flagNeg_q   <= aluResult[WIDTH-1];
        end
    end

    assign flag_zero  = flagZero_q;
    assign flag_carry = flagCarry_q;
    assign flag_neg   = flagNeg_q;
`else
    logic unusedFlagInputs;
    assign unusedFlagInputs = aluCarry ^ issue;

    assign flag_zero  = 1'b0;
    assign flag_carry = 1'b0;
    assign flag_neg   = 1'b0;
`endif

    assign result       = result_q;
    assign result_valid = resultValid_q;
    assign pc           = pc_q;
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer (WIDTH=8, DEPTH=16); expected flags apply
// only when ALU_SEQ_FLAGS_EN is defined, otherwise every flag must read 0.
module tb_alu_sequencer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int IW    = 4 + 2 * WIDTH;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] SHL = 3'b010;
    localparam logic [2:0] SHR = 3'b011;
    localparam logic [2:0] AND = 3'b100;
    localparam logic [2:0] OR  = 3'b101;
    localparam logic [2:0] XOR = 3'b110;
    localparam logic [2:0] NOT = 3'b111;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             prog_we = 1'b0;
    logic [AW-1:0]    prog_addr = '0;
    logic [IW-1:0]    prog_data = '0;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             result_ready = 1'b1;
    logic             flag_zero, flag_carry, flag_neg;
    logic             busy, done;
    logic [AW-1:0]    pc;

    typedef struct packed {
        logic [WIDTH-1:0] r;
        logic             z;
        logic             c;
        logic             n;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    alu_sequencer #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .result      (result),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .flag_zero   (flag_zero),
        .flag_carry  (flag_carry),
        .flag_neg    (flag_neg),
        .busy        (busy),
        .done        (done),
        .pc          (pc)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void pushExp(input logic [WIDTH-1:0] r, input logic z, input logic c, input logic n);
        exp_t e;
        e.r = r;
`ifdef ALU_SEQ_FLAGS_EN
        e.z = z;
        e.c = c;
        e.n = n;
`else
        e.z = 1'b0 & z;
        e.c = 1'b0 & c;
        e.n = 1'b0 & n;
`endif
        sb.push_back(e);
    endfunction

    // Monitor: every accepted result is popped from the scoreboard and compared.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && result_valid && result_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_result: got 0x%0h, expected no result", result);
            end else begin
                e = sb.pop_front();
                checkOutput("result", 32'(result), 32'(e.r));
                checkOutput("flag_zero", 32'(flag_zero), 32'(e.z));
                checkOutput("flag_carry", 32'(flag_carry), 32'(e.c));
                checkOutput("flag_neg", 32'(flag_neg), 32'(e.n));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [AW-1:0] addr, input logic halt, input logic [2:0] op,
                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = {halt, op, a, b};
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic startRun();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic finishRun(input string name, input int expCycles);
        int cycles = 0;
        while (!done && cycles < 200) begin
            tick();
            cycles++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_timeout: got no done pulse, expected done within 200 cycles", name);
        end else begin
            if (expCycles > 0) checkOutput({name, "_cycles"}, 32'(cycles), 32'(expCycles));
            checkOutput({name, "_valid_in_done"}, 32'(result_valid), 32'd0);
            checkOutput({name, "_busy_in_done"}, 32'(busy), 32'd1);
            tick();
            checkOutput({name, "_done_single"}, 32'(done), 32'd0);
            checkOutput({name, "_busy_after"}, 32'(busy), 32'd0);
            checkOutput({name, "_pc_after"}, 32'(pc), 32'd0);
        end
        checkOutput({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic loadBasic();
        applyStimulus(4'd0, 1'b0, ADD, 8'h17, 8'h13);
        applyStimulus(4'd1, 1'b0, SUB, 8'h0C, 8'h0D);
        applyStimulus(4'd2, 1'b1, SHL, 8'h05, 8'h02);
    endtask

    task automatic pushBasic();
        pushExp(8'h2A, 1'b0, 1'b0, 1'b0);
        pushExp(8'hFF, 1'b0, 1'b0, 1'b1);
        pushExp(8'h14, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #12;
        checkOutput("reset_result", 32'(result), 32'd0);
        checkOutput("reset_valid", 32'(result_valid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_pc", 32'(pc), 32'd0);
        checkOutput("reset_flags", 32'({flag_zero, flag_carry, flag_neg}), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        $display("[TB] basic three-instruction program at full throughput");
        loadBasic();
        pushBasic();
        startRun();
        finishRun("basic", 4);

        $display("[TB] back-pressure on second result, writes and start ignored while busy");
        pushBasic();
        startRun();
        tick();
        tick();
        result_ready = 1'b0;
        checkOutput("stall1_result", 32'(result), 32'hFF);
        checkOutput("stall1_pc", 32'(pc), 32'd2);
        start     = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 4'd2;
        prog_data = {1'b1, ADD, 8'h01, 8'h01};
        tick();
        checkOutput("stall2_result", 32'(result), 32'hFF);
        checkOutput("stall2_pc", 32'(pc), 32'd2);
        tick();
        checkOutput("stall3_result", 32'(result), 32'hFF);
        checkOutput("stall3_pc", 32'(pc), 32'd2);
        checkOutput("stall3_valid", 32'(result_valid), 32'd1);
        start        = 1'b0;
        prog_we      = 1'b0;
        result_ready = 1'b1;
        finishRun("stall", -1);

        $display("[TB] single-instruction shift, NOT and wrapping ADD");
        applyStimulus(4'd0, 1'b1, SHR, 8'h80, 8'h09);
        pushExp(8'h00, 1'b1, 1'b0, 1'b0);
        startRun();
        finishRun("shr_big", 2);
        applyStimulus(4'd0, 1'b1, NOT, 8'h5A, 8'h00);
        pushExp(8'hA5, 1'b0, 1'b0, 1'b1);
        startRun();
        finishRun("not", 2);
        applyStimulus(4'd0, 1'b1, ADD, 8'hFF, 8'h01);
        pushExp(8'h00, 1'b1, 1'b1, 1'b0);
        startRun();
        finishRun("add_wrap", 2);

        $display("[TB] logic and shift mix");
        applyStimulus(4'd0, 1'b0, AND, 8'hF0, 8'h3C);
        applyStimulus(4'd1, 1'b0, OR,  8'hF0, 8'h0C);
        applyStimulus(4'd2, 1'b0, XOR, 8'hFF, 8'h0F);
        applyStimulus(4'd3, 1'b0, SHL, 8'h81, 8'h01);
        applyStimulus(4'd4, 1'b0, SHR, 8'h81, 8'h01);
        applyStimulus(4'd5, 1'b1, SHL, 8'h01, 8'h0A);
        pushExp(8'h30, 1'b0, 1'b0, 1'b0);
        pushExp(8'hFC, 1'b0, 1'b0, 1'b1);
        pushExp(8'hF0, 1'b0, 1'b0, 1'b1);
        pushExp(8'h02, 1'b0, 1'b1, 1'b0);
        pushExp(8'h40, 1'b0, 1'b1, 1'b0);
        pushExp(8'h00, 1'b1, 1'b0, 1'b0);
        startRun();
        finishRun("mix", 7);

        $display("[TB] full memory without halt");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(AW'(i), 1'b0, ADD, WIDTH'(i), WIDTH'(i + 1));
            pushExp(WIDTH'(2 * i + 1), 1'b0, 1'b0, 1'b0);
        end
        startRun();
        finishRun("full", DEPTH + 1);

        $display("[TB] reset in the middle of a run, then restart");
        loadBasic();
        pushBasic();
        startRun();
        tick();
        tick();
        reset = 1'b1;
        #1;
        sb.delete();
        checkOutput("midreset_result", 32'(result), 32'd0);
        checkOutput("midreset_valid", 32'(result_valid), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_done", 32'(done), 32'd0);
        checkOutput("midreset_pc", 32'(pc), 32'd0);
        checkOutput("midreset_flags", 32'({flag_zero, flag_carry, flag_neg}), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        pushBasic();
        startRun();
        finishRun("restart", 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
